// File: rtl/sram_pkg.sv
// Shared types and constants for the multi-read-port SRAM that clears itself after reset.
// sram_clr_state_t : states of the clear sequencer
// BYTE_WIDTH       : width of one write-mask lane
package sram_pkg;

    typedef enum logic {
        CLEARING,
        READY
    } sram_clr_state_t;

    localparam int BYTE_WIDTH = 8;

endpackage

// File: rtl/sram_clear_sequencer.sv
// Clear sequencer. After reset it sweeps every word once with CLEAR_VALUE.
// It also owns the mux that feeds the array write port, so user writes reach the array only in READY.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// CLEARING | writing CLEAR_VALUE to word[counter]; user access ignored
// READY    | array usable; user write port drives the array
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   user_we/addr/mask/data  user write request
//   ready                   registered, high once the array is usable
//   access_ok               state == READY; gates user reads and writes
//   arr_we/addr/mask/data   muxed write port into the storage array
module sram_clear_sequencer
    import sram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    SIZE           = 1024,
    parameter int                    ADDR_WIDTH     = $clog2(SIZE),
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             user_we,
    input  logic [ADDR_WIDTH-1:0]            user_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] user_mask,
    input  logic [DATA_WIDTH-1:0]            user_data,
    output logic                             ready,
    output logic                             access_ok,
    output logic                             arr_we,
    output logic [ADDR_WIDTH-1:0]            arr_addr,
    output logic [DATA_WIDTH/BYTE_WIDTH-1:0] arr_mask,
    output logic [DATA_WIDTH-1:0]            arr_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   SIZE_W      = (ADDR_WIDTH + 1)'(SIZE);
    localparam sram_clr_state_t       RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEARING : READY;

    sram_clr_state_t       state;
    logic [ADDR_WIDTH-1:0] counter;
    logic                  clearing;
    logic                  user_in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RESET_STATE;
            counter <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEARING: begin
                    // The last word is written on this edge, so ready rises together with the state change.
                    if (counter == LAST_ADDR) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                READY: begin
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign clearing  = (state == CLEARING);
    assign access_ok = (state == READY);

    // Only matters for non-power-of-2 SIZE: out-of-range writes are dropped.
    assign user_in_range = ({1'b0, user_addr} < SIZE_W);

    assign arr_we   = clearing ? 1'b1        : (user_we & user_in_range);
    assign arr_addr = clearing ? counter     : user_addr;
    assign arr_mask = clearing ? '1          : user_mask;
    assign arr_data = clearing ? CLEAR_VALUE : user_data;

endmodule

// File: rtl/sram_nr1w_clr.sv
// Synchronous SRAM with NUM_READ_PORTS registered read ports and one byte-masked write port.
// The sequencer clears the whole array after reset.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   ready          high when the array is usable
//   read_en        per-port read enable
//   read_addr      per-port read address
//   read_data      per-port registered read data (cleared by reset)
//   write_en       write enable
//   write_addr     write address
//   write_mask     byte enables; bit i covers data bits [8i+7:8i]
//   write_data     write data
module sram_nr1w_clr
    import sram_pkg::*;
#(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    SIZE              = 1024,
    parameter int                    NUM_READ_PORTS    = 2,
    parameter string                 READ_DURING_WRITE = "NEW_DATA",
    parameter int                    CLEAR_ON_RESET    = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE       = '0,
    parameter int                    ADDR_WIDTH        = $clog2(SIZE)
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    output logic                                           ready,
    input  logic [NUM_READ_PORTS-1:0]                      read_en,
    input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]      read_addr,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]      read_data,
    input  logic                                           write_en,
    input  logic [ADDR_WIDTH-1:0]                          write_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]               write_mask,
    input  logic [DATA_WIDTH-1:0]                          write_data
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam bit BYPASS    = (READ_DURING_WRITE == "NEW_DATA");

    logic                  access_ok;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [NUM_BYTES-1:0]  arr_mask;
    logic [DATA_WIDTH-1:0] arr_data;

    sram_clear_sequencer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .SIZE           (SIZE),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .CLEAR_VALUE    (CLEAR_VALUE)
    ) u_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .user_we   (write_en),
        .user_addr (write_addr),
        .user_mask (write_mask),
        .user_data (write_data),
        .ready     (ready),
        .access_ok (access_ok),
        .arr_we    (arr_we),
        .arr_addr  (arr_addr),
        .arr_mask  (arr_mask),
        .arr_data  (arr_data)
    );

    // Plain storage array with per-byte write enables.
    // A vendor macro could replace this later; the bypass below stays in this module.
    logic [DATA_WIDTH-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (arr_we) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (arr_mask[b]) begin
                    mem[arr_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= arr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
        logic [DATA_WIDTH-1:0] old_word;
        logic [DATA_WIDTH-1:0] rd_word;
        logic [DATA_WIDTH-1:0] q;

        assign old_word = mem[read_addr[p]];

        // Byte-accurate bypass of a same-cycle write.
        // Every port hitting the address sees the same merged word.
        always_comb begin
            rd_word = old_word;
            if (BYPASS && arr_we && (arr_addr == read_addr[p])) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (arr_mask[b]) begin
                        rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = arr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                q <= '0;
            end else if (access_ok && read_en[p]) begin
                q <= rd_word;
            end
        end

        assign read_data[p] = q;
    end

endmodule

// File: tb/tb_sram_nr1w_clr.sv
// Randomised scoreboard bench for sram_nr1w_clr.
// Main DUT: 16 words, 3 read ports, NEW_DATA collisions, clear to DEADBEEF.
// Second DUT: 16 words, 1 read port, no clear after reset.
module tb_sram_nr1w_clr;

    localparam logic [31:0] CV = 32'hDEADBEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  rdy;
    logic [2:0]            ren;
    logic [2:0][3:0]       raddr;
    logic [2:0][31:0]      rdata;
    logic                  we;
    logic [3:0]            waddr;
    logic [3:0]            wmask;
    logic [31:0]           wdata;

    logic                  rst_nc;
    logic                  rdy_nc;
    logic [0:0]            ren_nc;
    logic [0:0][3:0]       raddr_nc;
    logic [0:0][31:0]      rdata_nc;
    logic                  we_nc;
    logic [3:0]            waddr_nc;
    logic [3:0]            wmask_nc;
    logic [31:0]           wdata_nc;

    sram_nr1w_clr #(
        .DATA_WIDTH(32), .SIZE(16), .NUM_READ_PORTS(3), .READ_DURING_WRITE("NEW_DATA"),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) dut (
        .clk(clk), .reset_n(rst_n), .ready(rdy),
        .read_en(ren), .read_addr(raddr), .read_data(rdata),
        .write_en(we), .write_addr(waddr), .write_mask(wmask), .write_data(wdata)
    );

    sram_nr1w_clr #(
        .DATA_WIDTH(32), .SIZE(16), .NUM_READ_PORTS(1), .READ_DURING_WRITE("NEW_DATA"),
        .CLEAR_ON_RESET(0), .CLEAR_VALUE(32'h0)
    ) dut_nc (
        .clk(clk), .reset_n(rst_nc), .ready(rdy_nc),
        .read_en(ren_nc), .read_addr(raddr_nc), .read_data(rdata_nc),
        .write_en(we_nc), .write_addr(waddr_nc), .write_mask(wmask_nc), .write_data(wdata_nc)
    );

    typedef struct packed {
        logic             rdy;
        logic [2:0][31:0] d;
    } exp_t;

    exp_t             exp_q[$];
    int               errors = 0;
    int               checks = 0;

    // Reference model: the whole array, the visible read registers, and the cycles left before ready.
    logic [31:0]      mm [16];
    logic [2:0][31:0] last;
    int               clr_left;
    bit               m_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // A reset makes the whole array read back as CLEAR_VALUE once the 16 clear cycles are done.
    task automatic model_reset();
        for (int i = 0; i < 16; i++) mm[i] = CV;
        last     = '0;
        clr_left = 16;
        m_ready  = 1'b0;
    endtask

    // Drive one cycle of stimulus and push what the DUT must show after the next edge.
    task automatic issue(input logic [2:0] r_en, input logic [2:0][3:0] r_a,
                         input logic w_en, input logic [3:0] w_a,
                         input logic [3:0] w_m, input logic [31:0] w_d);
        exp_t e;
        @(negedge clk);
        ren = r_en; raddr = r_a; we = w_en; waddr = w_a; wmask = w_m; wdata = w_d;
        if (m_ready) begin
            for (int p = 0; p < 3; p++) begin
                if (r_en[p]) last[p] = (w_en && w_a == r_a[p]) ? merge(mm[r_a[p]], w_d, w_m) : mm[r_a[p]];
            end
            if (w_en) mm[w_a] = merge(mm[w_a], w_d, w_m);
        end else begin
            clr_left--;
            if (clr_left == 0) m_ready = 1'b1;
        end
        e.rdy = m_ready;
        e.d   = last;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        issue(3'b000, '0, 1'b0, 4'd0, 4'd0, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ready", {31'd0, rdy}, {31'd0, e.rdy});
                for (int p = 0; p < 3; p++) chk($sformatf("read_data[%0d]", p), rdata[p], e.d[p]);
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; rst_nc = 1'b0;
        ren = '0; raddr = '0; we = 1'b0; waddr = '0; wmask = '0; wdata = '0;
        ren_nc = '0; raddr_nc = '0; we_nc = 1'b0; waddr_nc = '0; wmask_nc = '0; wdata_nc = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset ready", {31'd0, rdy}, 32'd0);
        for (int p = 0; p < 3; p++) chk($sformatf("reset read_data[%0d]", p), rdata[p], 32'd0);

        // Clear: user traffic must be ignored and read_data must stay 0.
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 16; i++)
            issue(3'b111, {4'($urandom), 4'($urandom), 4'($urandom)}, 1'b1, 4'($urandom), 4'hF, $urandom);
        for (int i = 0; i < 16; i++)
            issue(3'b111, {4'((i + 11) % 16), 4'((i + 5) % 16), 4'(i)}, 1'b0, 4'd0, 4'd0, 32'd0);

        // Byte mask.
        issue(3'b000, '0, 1'b1, 4'd3, 4'hF, 32'h11223344);
        issue(3'b000, '0, 1'b1, 4'd3, 4'b0101, 32'hAABBCCDD);
        issue(3'b001, {4'd0, 4'd0, 4'd3}, 1'b0, 4'd0, 4'd0, 32'd0);
        issue(3'b000, '0, 1'b1, 4'd3, 4'b0000, 32'hFFFFFFFF);
        issue(3'b010, {4'd0, 4'd3, 4'd0}, 1'b0, 4'd0, 4'd0, 32'd0);

        // Two ports colliding with a partial write.
        issue(3'b000, '0, 1'b1, 4'd5, 4'hF, 32'h11223344);
        issue(3'b011, {4'd0, 4'd5, 4'd5}, 1'b1, 4'd5, 4'b1000, 32'hAABBCCDD);
        issue(3'b000, '0, 1'b0, 4'd0, 4'd0, 32'd0);

        // Port 2 holds while ports 0/1 keep reading, even when its word is rewritten.
        issue(3'b000, '0, 1'b1, 4'd9, 4'hF, 32'h5);
        issue(3'b100, {4'd9, 4'd0, 4'd0}, 1'b0, 4'd0, 4'd0, 32'd0);
        for (int i = 0; i < 4; i++)
            issue(3'b011, {4'd0, 4'(i + 1), 4'(i + 10)}, 1'b1, 4'd9, 4'hF, $urandom);

        // Random traffic, biased towards a few addresses to provoke collisions.
        for (int i = 0; i < 300; i++) begin
            logic [2:0][3:0] a;
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            for (int p = 0; p < 3; p++) a[p] = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
            issue(3'($urandom), a, 1'($urandom),
                  narrow ? 4'($urandom_range(0, 3)) : 4'($urandom), 4'($urandom), $urandom);
        end

        // Overwrite words 0..6, then reset at clear cycle 7 and again after release.
        for (int i = 0; i < 7; i++) issue(3'b000, '0, 1'b1, 4'(i), 4'hF, 32'h0BAD0000 + i);
        @(posedge clk); #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async reset ready", {31'd0, rdy}, 32'd0);
        for (int p = 0; p < 3; p++) chk($sformatf("async reset read_data[%0d]", p), rdata[p], 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 7; i++) idle();
        @(posedge clk); #2 rst_n = 1'b0;
        model_reset();
        #1 chk("mid-clear reset ready", {31'd0, rdy}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) idle();
        for (int i = 0; i < 16; i++)
            issue(3'b111, {4'(15 - i), 4'((i + 3) % 16), 4'(i)}, 1'b0, 4'd0, 4'd0, 32'd0);
        idle();
        @(posedge clk); #2;

        // Instance without clear: ready one edge after release, then a plain write/read.
        chk("noclr ready in reset", {31'd0, rdy_nc}, 32'd0);
        @(posedge clk); #2 rst_nc = 1'b1;
        #1 chk("noclr ready before edge", {31'd0, rdy_nc}, 32'd0);
        @(posedge clk); #1;
        chk("noclr ready after edge", {31'd0, rdy_nc}, 32'd1);
        @(negedge clk);
        we_nc = 1'b1; waddr_nc = 4'd2; wmask_nc = 4'hF; wdata_nc = 32'h1;
        @(negedge clk);
        we_nc = 1'b0; ren_nc = 1'b1; raddr_nc[0] = 4'd2;
        @(posedge clk); #1;
        chk("noclr read_data", rdata_nc[0], 32'h1);
        @(negedge clk);
        ren_nc = 1'b0; we_nc = 1'b1; waddr_nc = 4'd2; wmask_nc = 4'b0010; wdata_nc = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("noclr hold", rdata_nc[0], 32'h1);
        @(negedge clk);
        we_nc = 1'b0; ren_nc = 1'b1;
        @(posedge clk); #1;
        chk("noclr masked", rdata_nc[0], 32'h0000_FF01);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
